// File: rtl/axis_gain_ramp_mc_if.sv
// AXI-Stream sample bus used on both sides of the gain stage.
`timescale 1ns/1ps
interface axis_gain_ramp_mc_if #(
    parameter int unsigned DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/axis_gain_ramp_mc.sv
// Multichannel AXIS volume stage: per-frame gain ramp, 3-stage multiply,
// round half-up and saturate, full backpressure.
`timescale 1ns/1ps
module axis_gain_ramp_mc #(
    parameter int unsigned DATA_WIDTH  = 24,
    parameter int unsigned SCALE_WIDTH = 16,
    parameter int unsigned GAIN_FRAC   = 16,
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned RAMP_STEP   = 'h100
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SCALE_WIDTH-1:0] i_scale,
    input  logic                   i_mute,
    axis_gain_ramp_mc_if.slave     s_axis,
    axis_gain_ramp_mc_if.master    m_axis,
    output logic [GAIN_FRAC:0]     o_gain,
    output logic                   o_ramping,
    output logic                   o_frame_err
);
    localparam int unsigned GAIN_W = GAIN_FRAC + 1;
    localparam int unsigned PROD_W = DATA_WIDTH + GAIN_FRAC + 2;
    localparam int unsigned SHR_W  = PROD_W - GAIN_FRAC;
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int          SHIFT  = int'(GAIN_FRAC) + 1 - int'(SCALE_WIDTH);

    localparam logic [GAIN_W-1:0]            STEP       = GAIN_W'(RAMP_STEP);
    localparam logic [CH_W-1:0]              CH_LAST    = CH_W'(NUM_CH - 1);
    localparam logic signed [PROD_W-1:0]     ROUND_BIAS = PROD_W'(1) << (GAIN_FRAC - 1);
    localparam logic [DATA_WIDTH-1:0]        SAT_MAX    = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0]        SAT_MIN    = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Volume word path
    logic [SCALE_WIDTH-1:0] scale_meta;
    logic [SCALE_WIDTH-1:0] scale_sync;
    logic [GAIN_W-1:0]      scale_gain;
    logic [GAIN_W-1:0]      target;
    logic [GAIN_W-1:0]      target_nxt;
    logic [GAIN_W-1:0]      gain_nxt;

    // Framing
    logic [CH_W-1:0] ch;
    logic            accept;
    logic            ch_at_last;
    logic            frame_end;
    logic            frame_bad;

    // Pipeline
    logic                     ce;
    logic                     s1_valid;
    logic [DATA_WIDTH-1:0]    s1_data;
    logic [GAIN_W-1:0]        s1_gain;
    logic                     s1_last;
    logic signed [PROD_W-1:0] mult_a;
    logic signed [PROD_W-1:0] mult_b;
    logic                     s2_valid;
    logic signed [PROD_W-1:0] s2_prod;
    logic                     s2_last;
    logic signed [SHR_W-1:0]  shr;
    logic [DATA_WIDTH-1:0]    sat;
    logic                     out_valid;
    logic [DATA_WIDTH-1:0]    out_data;
    logic                     out_last;

    // Align the volume word to the Q1.GAIN_FRAC gain format.
    if (SHIFT >= 0) begin : g_shl
        assign scale_gain = GAIN_W'(scale_sync) << SHIFT;
    end else begin : g_shr
        assign scale_gain = GAIN_W'(scale_sync >> (-SHIFT));
    end

    assign ce           = ~out_valid | m_axis.ready;
    assign s_axis.ready = ce & ~rst;
    assign accept       = s_axis.valid & s_axis.ready;
    assign ch_at_last   = (ch == CH_LAST);
    assign frame_end    = accept & (s_axis.last | ch_at_last);
    assign frame_bad    = accept & (s_axis.last ^ ch_at_last);

    assign m_axis.valid = out_valid;
    assign m_axis.data  = out_data;
    assign m_axis.last  = out_last;

    // Target selection and per-frame ramp step toward it.
    always_comb begin
        target_nxt = i_mute ? '0 : scale_gain;
        gain_nxt   = o_gain;
        if (frame_end) begin
            if (target >= o_gain) begin
                gain_nxt = ((target - o_gain) <= STEP) ? target : o_gain + STEP;
            end else begin
                gain_nxt = ((o_gain - target) <= STEP) ? target : o_gain - STEP;
            end
        end
    end

    // Two-flop synchroniser for the asynchronous volume word, then target register.
    always_ff @(posedge clk) begin
        if (rst) begin
            scale_meta <= '0;
            scale_sync <= '0;
            target     <= '0;
        end else begin
            scale_meta <= i_scale;
            scale_sync <= scale_meta;
            target     <= target_nxt;
        end
    end

    // Applied gain; ramping flag tracks the post-edge gain/target pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_gain    <= '0;
            o_ramping <= 1'b0;
        end else begin
            o_gain    <= gain_nxt;
            o_ramping <= (gain_nxt != target_nxt);
        end
    end

    // Channel counter and framing-error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch          <= '0;
            o_frame_err <= 1'b0;
        end else begin
            o_frame_err <= frame_bad;
            if (frame_end) begin
                ch <= '0;
            end else if (accept) begin
                ch <= ch + CH_W'(1);
            end
        end
    end

    // Multiply operands, sign-extended to the full product width.
    always_comb begin
        mult_a = PROD_W'($signed(s1_data));
        mult_b = PROD_W'($signed({1'b0, s1_gain}));
    end

    // Round half-up, then clamp into the signed sample range.
    assign shr = SHR_W'((s2_prod + ROUND_BIAS) >>> GAIN_FRAC);

    always_comb begin
        sat = shr[DATA_WIDTH-1:0];
        if (!((&shr[SHR_W-1:DATA_WIDTH-1]) | ~(|shr[SHR_W-1:DATA_WIDTH-1]))) begin
            sat = shr[SHR_W-1] ? SAT_MIN : SAT_MAX;
        end
    end

    // Three-stage pipeline; every stage advances together on ce.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_gain   <= '0;
            s1_last   <= 1'b0;
            s2_valid  <= 1'b0;
            s2_prod   <= '0;
            s2_last   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (ce) begin
            s1_valid  <= s_axis.valid;
            s1_data   <= s_axis.data;
            s1_gain   <= o_gain;
            s1_last   <= s_axis.last;
            s2_valid  <= s1_valid;
            s2_prod   <= mult_a * mult_b;
            s2_last   <= s1_last;
            out_valid <= s2_valid;
            out_data  <= sat;
            out_last  <= s2_last;
        end
    end
endmodule
